// File: rtl/servo_angle_pid_if.sv
// Sample/command bus between the position sampler, the PID controller and
// the downstream servo PWM generator.
interface servo_angle_pid_if;
   logic        enable;
   logic [11:0] setpoint;
   logic [11:0] position;
   logic        sample_valid;
   logic [11:0] angle;
   logic        angle_valid;
   logic        busy;

   modport master (
      output enable, setpoint, position, sample_valid,
      input  angle, angle_valid, busy
   );

   modport slave (
      input  enable, setpoint, position, sample_valid,
      output angle, angle_valid, busy
   );
endinterface

// File: rtl/servo_angle_pid.sv
// Single-axis discrete PID: position sample + setpoint -> 12-bit tilt angle.
// Multi-cycle sequence (ERR, P, I, D, OUT) sharing one signed multiplier.
module servo_angle_pid #(
   parameter int KP     = 16,
   parameter int KI     = 1,
   parameter int KD     = 8,
   parameter int SHIFT  = 4,
   parameter int ILIMIT = 8192,
   parameter int CENTER = 2048
) (
   input logic               clock,
   input logic               reset,
   servo_angle_pid_if.slave  bus
);

   typedef enum logic [2:0] {
      S_IDLE, S_ERR, S_PT, S_IT, S_DT, S_OUT
   } state_t;

   state_t state, state_nx;

   logic [11:0]        sp_q, pos_q;
   logic signed [12:0] e_prev;      // holds the current error from ERR onward
   logic signed [17:0] integ;
   logic signed [13:0] d_q;
   logic               first;
   logic signed [31:0] acc;
   logic [11:0]        angle_q;
   logic               av_q;

   logic signed [12:0] e_w;
   logic signed [18:0] isum;
   logic signed [17:0] integ_nx;
   logic signed [13:0] d_w;
   logic signed [7:0]  mul_a;
   logic signed [17:0] mul_b;
   logic signed [25:0] prod;
   logic signed [31:0] u;
   logic signed [32:0] osum;
   logic [11:0]        angle_nx;

   // State register
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_nx;
   end

   // Next-state: fixed sequence, enable low aborts to IDLE from anywhere
   always_comb begin
      state_nx = state;
      if (!bus.enable) begin
         state_nx = S_IDLE;
      end else begin
         case (state)
            S_IDLE:  if (bus.sample_valid) state_nx = S_ERR;
            S_ERR:   state_nx = S_PT;
            S_PT:    state_nx = S_IT;
            S_IT:    state_nx = S_DT;
            S_DT:    state_nx = S_OUT;
            S_OUT:   state_nx = S_IDLE;
            default: state_nx = S_IDLE;
         endcase
      end
   end

   // Error, clamped integrator, derivative, shared multiplier and output clamp
   always_comb begin
      e_w  = $signed({1'b0, sp_q}) - $signed({1'b0, pos_q});
      isum = 19'(integ) + 19'(e_w);
      integ_nx = isum[17:0];
      if (isum > 19'(ILIMIT))       integ_nx = 18'(ILIMIT);
      else if (isum < 19'(-ILIMIT)) integ_nx = 18'(-ILIMIT);
      d_w = 14'(e_w) - 14'(e_prev);

      mul_a = '0;
      mul_b = '0;
      case (state)
         S_PT: begin mul_a = 8'(KP); mul_b = 18'(e_prev); end
         S_IT: begin mul_a = 8'(KI); mul_b = integ;       end
         S_DT: begin mul_a = 8'(KD); mul_b = 18'(d_q);    end
         default: ;
      endcase
      prod = 26'(mul_a) * 26'(mul_b);

      u    = acc >>> SHIFT;
      osum = 33'(u) + 33'(CENTER);
      if (osum < 33'sd0)         angle_nx = '0;
      else if (osum > 33'sd4095) angle_nx = '1;
      else                       angle_nx = osum[11:0];
   end

   // Datapath registers advanced by the current state
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sp_q    <= '0;
         pos_q   <= '0;
         e_prev  <= '0;
         integ   <= '0;
         d_q     <= '0;
         first   <= 1'b1;
         acc     <= '0;
         angle_q <= 12'(CENTER);
         av_q    <= 1'b0;
      end else begin
         av_q <= 1'b0;
         if (!bus.enable) begin
            integ  <= '0;
            e_prev <= '0;
            first  <= 1'b1;
         end else begin
            case (state)
               S_IDLE: if (bus.sample_valid) begin
                  sp_q  <= bus.setpoint;
                  pos_q <= bus.position;
               end
               S_ERR: begin
                  integ  <= integ_nx;
                  d_q    <= first ? '0 : d_w;
                  e_prev <= e_w;
                  first  <= 1'b0;
               end
               S_PT:       acc <= 32'(prod);
               S_IT, S_DT: acc <= acc + 32'(prod);
               S_OUT: begin
                  angle_q <= angle_nx;
                  av_q    <= 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

   assign bus.angle       = angle_q;
   assign bus.angle_valid = av_q;
   assign bus.busy        = (state != S_IDLE);

endmodule

// File: tb/tb_servo_angle_pid.sv
// Directed bench for servo_angle_pid with hand-computed angle values.
module tb_servo_angle_pid;

   logic clock = 1'b0;
   logic reset = 1'b0;
   int   passed = 0;
   int   total  = 0;

   servo_angle_pid_if bus();

   servo_angle_pid dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   // Drive one sample at the current negedge and wait for angle_valid.
   // lat = number of cycles from capture edge to angle_valid, -1 on timeout.
   task automatic send_and_wait(input logic [11:0] sp, input logic [11:0] pos,
                                output logic [11:0] got, output int lat);
      bus.setpoint     = sp;
      bus.position     = pos;
      bus.sample_valid = 1'b1;
      @(negedge clock);
      bus.sample_valid = 1'b0;
      lat = -1;
      for (int i = 1; i <= 10; i++) begin
         @(negedge clock);
         if (bus.angle_valid === 1'b1) begin
            lat = i;
            break;
         end
      end
      got = bus.angle;
   endtask

   task automatic restart();
      bus.enable = 1'b0;
      @(negedge clock);
      bus.enable = 1'b1;
      @(negedge clock);
   endtask

   task automatic test_reset();
      bus.enable = 1'b1;
      bus.sample_valid = 1'b0;
      bus.setpoint = '0;
      bus.position = '0;
      reset = 1'b0;
      repeat (3) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      total++; if (bus.angle !== 12'd2048) $display("FAIL reset_angle got %0d want 2048", bus.angle); else passed++;
      total++; if (bus.angle_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", bus.angle_valid); else passed++;
      total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got %b want 0", bus.busy); else passed++;
   endtask

   task automatic test_zero_error();
      logic [11:0] a; int lat;
      send_and_wait(12'd2048, 12'd2048, a, lat);
      total++; if (lat !== 5) $display("FAIL zero_latency got %0d want 5", lat); else passed++;
      total++; if (a !== 12'd2048) $display("FAIL zero_angle got %0d want 2048", a); else passed++;
      @(negedge clock);
      total++; if (bus.angle_valid !== 1'b0) $display("FAIL zero_pulse_width got %b want 0", bus.angle_valid); else passed++;
      total++; if (bus.busy !== 1'b0) $display("FAIL zero_busy_after got %b want 0", bus.busy); else passed++;
   endtask

   task automatic test_step();
      logic [11:0] a; int lat;
      restart();
      send_and_wait(12'd2148, 12'd2048, a, lat);
      total++; if (a !== 12'd2154) $display("FAIL step1_angle got %0d want 2154", a); else passed++;
      send_and_wait(12'd2148, 12'd2048, a, lat);
      total++; if (a !== 12'd2160) $display("FAIL step2_angle got %0d want 2160", a); else passed++;
      send_and_wait(12'd2148, 12'd2148, a, lat);
      total++; if (a !== 12'd2010) $display("FAIL step3_angle got %0d want 2010", a); else passed++;
   endtask

   task automatic test_back_to_back();
      logic [11:0] a; int lat;
      restart();
      send_and_wait(12'd2148, 12'd2048, a, lat);
      total++; if (bus.busy !== 1'b0) $display("FAIL b2b_busy got %b want 0", bus.busy); else passed++;
      send_and_wait(12'd2148, 12'd2048, a, lat);
      total++; if (lat !== 5) $display("FAIL b2b_latency got %0d want 5", lat); else passed++;
      total++; if (a !== 12'd2160) $display("FAIL b2b_angle got %0d want 2160", a); else passed++;
   endtask

   task automatic test_saturation();
      logic [11:0] a; int lat;
      restart();
      send_and_wait(12'd4095, 12'd0, a, lat);
      total++; if (a !== 12'd4095) $display("FAIL sat_high got %0d want 4095", a); else passed++;
      restart();
      send_and_wait(12'd0, 12'd4095, a, lat);
      total++; if (a !== 12'd0) $display("FAIL sat_low got %0d want 0", a); else passed++;
   endtask

   task automatic test_integrator_clamp();
      logic [11:0] a; int lat;
      restart();
      for (int k = 0; k < 3; k++) begin
         send_and_wait(12'd4095, 12'd0, a, lat);
         total++; if (a !== 12'd4095) $display("FAIL clamp_sat%0d got %0d want 4095", k, a); else passed++;
      end
      // e=0, d=-4095, integ=8192: (8192 - 32760) >>> 4 = -1536 -> 512
      send_and_wait(12'd0, 12'd0, a, lat);
      total++; if (a !== 12'd512) $display("FAIL clamp_probe got %0d want 512", a); else passed++;
   endtask

   task automatic test_drop_while_busy();
      int cnt = 0;
      restart();
      bus.setpoint = 12'd2148; bus.position = 12'd2048; bus.sample_valid = 1'b1;
      @(negedge clock);
      bus.sample_valid = 1'b0;
      @(negedge clock);
      bus.setpoint = 12'd4095; bus.position = 12'd0; bus.sample_valid = 1'b1;
      @(negedge clock);
      bus.sample_valid = 1'b0;
      for (int i = 0; i < 12; i++) begin
         if (bus.angle_valid === 1'b1) cnt++;
         @(negedge clock);
      end
      total++; if (cnt !== 1) $display("FAIL drop_valid_count got %0d want 1", cnt); else passed++;
      total++; if (bus.angle !== 12'd2154) $display("FAIL drop_angle got %0d want 2154", bus.angle); else passed++;
   endtask

   task automatic test_enable_abort();
      logic [11:0] a; int lat; int cnt = 0;
      restart();
      send_and_wait(12'd2148, 12'd2048, a, lat);
      total++; if (a !== 12'd2154) $display("FAIL abort_pre_angle got %0d want 2154", a); else passed++;
      bus.setpoint = 12'd4095; bus.position = 12'd0; bus.sample_valid = 1'b1;
      @(negedge clock);
      bus.sample_valid = 1'b0;
      @(negedge clock);
      bus.enable = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clock);
         if (bus.angle_valid === 1'b1) cnt++;
      end
      total++; if (cnt !== 0) $display("FAIL abort_valid_count got %0d want 0", cnt); else passed++;
      total++; if (bus.angle !== 12'd2154) $display("FAIL abort_angle_hold got %0d want 2154", bus.angle); else passed++;
      total++; if (bus.busy !== 1'b0) $display("FAIL abort_busy got %b want 0", bus.busy); else passed++;
      bus.enable = 1'b1;
      send_and_wait(12'd2148, 12'd2048, a, lat);
      total++; if (a !== 12'd2154) $display("FAIL abort_fresh_angle got %0d want 2154", a); else passed++;
   endtask

   task automatic test_reset_mid();
      logic [11:0] a; int lat;
      restart();
      send_and_wait(12'd4095, 12'd0, a, lat);
      total++; if (a !== 12'd4095) $display("FAIL midrst_pre_angle got %0d want 4095", a); else passed++;
      bus.setpoint = 12'd2148; bus.position = 12'd2048; bus.sample_valid = 1'b1;
      @(negedge clock);
      bus.sample_valid = 1'b0;
      @(negedge clock);
      #1 reset = 1'b0;
      #1;
      total++; if (bus.angle !== 12'd2048) $display("FAIL midrst_angle got %0d want 2048", bus.angle); else passed++;
      total++; if (bus.busy !== 1'b0) $display("FAIL midrst_busy got %b want 0", bus.busy); else passed++;
      total++; if (bus.angle_valid !== 1'b0) $display("FAIL midrst_valid got %b want 0", bus.angle_valid); else passed++;
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
   endtask

   initial begin
      test_reset();
      test_zero_error();
      test_step();
      test_back_to_back();
      test_saturation();
      test_integrator_clamp();
      test_drop_while_busy();
      test_enable_abort();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/servo_angle_pid.md
# servo_angle_pid

Discrete PID controller that converts a ball-position sample and a position setpoint into a 12-bit plate-tilt angle command for one axis. It sits directly upstream of the servo PWM generator and drives that block's `angle` input. One instance is used per plate axis, and each is fed by the touch-panel position sampler. Arithmetic runs as a short multi-cycle sequence on a single shared multiplier.

## Interface
- `KP`, 16: proportional gain, signed 8-bit integer.
- `KI`, 1: integral gain, signed 8-bit integer.
- `KD`, 8: derivative gain, signed 8-bit integer.
- `SHIFT`, 4: arithmetic right shift applied to the summed terms (gain scaling).
- `ILIMIT`, 8192: symmetric integrator clamp magnitude, positive, below 2^17.
- `CENTER`, 2048: angle output at zero control effort.

Ports:
- `clock` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `enable` input 1: controller run enable.
- `setpoint` input 12: target position, unsigned.
- `position` input 12: measured position, unsigned.
- `sample_valid` input 1: one-cycle strobe marking `setpoint`/`position` valid.
- `angle` output 12: angle command, unsigned 0..4095, registered.
- `angle_valid` output 1: one-cycle strobe when `angle` updates.
- `busy` output 1: high whenever the FSM is not in IDLE.

## Operation
- Reset (`reset`=0, asynchronous) sets the following values:
  - `angle`=CENTER, `angle_valid`=0, `busy`=0.
  - Integrator=0, previous error=0, first-sample flag=1, state IDLE.
- The FSM sequence is IDLE → ERR → PT → IT → DT → OUT → IDLE.
- **IDLE:** if `enable`=1 and `sample_valid`=1, capture both inputs and go to ERR. Otherwise stay.
- **ERR:** compute the following, then go to PT.
  - e = setpoint − position, signed 13-bit.
  - integ = clamp(integ + e, −ILIMIT, +ILIMIT), signed 18-bit.
  - d = e − e_prev, signed 14-bit. d is forced to 0 when the first-sample flag is set.
  - Store e_prev = e and clear the first-sample flag.
- **PT:** acc = KP·e, signed 32-bit.
- **IT:** acc += KI·integ.
- **DT:** acc += KD·d.
- **OUT:** compute and register the result, then return to IDLE.
  - u = acc >>> SHIFT, arithmetic shift, so rounding is toward −∞.
  - `angle` = clamp(CENTER + u, 0, 4095).
  - Pulse `angle_valid`.
- `sample_valid` asserted while `busy`=1 is dropped. It is not queued.
- `enable`=0 takes effect synchronously in any state:
  - Return to IDLE and abort any computation.
  - Clear the integrator and e_prev, and set the first-sample flag.
  - `angle` holds its last value and `angle_valid` stays 0.
- Reset asserted mid-sequence aborts immediately to the reset values above.
- There is exactly one multiplier, used once each in PT, IT and DT.

## Timing
- Capture edge N is the edge where IDLE sees `sample_valid`.
  - `busy` is high from after edge N until edge N+5.
  - `angle` and `angle_valid` update at edge N+5, so latency is 5 cycles.
- `angle_valid` stays high for exactly one cycle.
- The next sample can be accepted at edge N+6 at the earliest, giving a maximum rate of one sample per 6 cycles.
- `angle` changes only at the OUT edge or at reset.

## Test plan
All scenarios use the default parameters.
1. Reset asserted, then released with `enable`=1 → `angle`=2048, `angle_valid`=0, `busy`=0. Assert reset low mid-sequence → outputs return to these values asynchronously.
2. setpoint=2048, position=2048, strobe → after 5 cycles `angle`=2048 and `angle_valid` pulses for 1 cycle.
3. PID step response, with setpoint=2148 and position=2048 unless stated:
   - First sample (e=100, d=0) → `angle`=2154.
   - Repeat the sample (integ=200, d=0) → `angle`=2160.
   - Then position=2148 (e=0, integ=200, d=−100) → (200−800)>>>4=−38 → `angle`=2010.
4. Saturation, each from a fresh start:
   - setpoint=4095, position=0, first sample → u=4350 → `angle`=4095.
   - setpoint=0, position=4095 → u=−4351 → `angle`=0.
5. Integrator clamp: three samples with e=4095 → integ goes 4095, 8190, 8192, and is never 12285.
6. Boundary conditions:
   - Strobe again 2 cycles after acceptance → dropped, with exactly one `angle_valid`.
   - Drop `enable` at the PT state → no `angle_valid` and `angle` held.
   - Re-enable and strobe with e=100 → `angle`=2154, confirming the integrator and first-sample flag were cleared.
